fire_layer_scheduler: RTL

Sequences a chain of fire-layer engines (squeeze/expand datapaths) that share one feature-map RAM, running exactly one layer at a time. It raises each engine's enable, counts the output-sample strobes the engine returns, and waits for its level `finish`. It then returns the one-cycle `ram_feedback` acknowledge and advances to the next layer. It sits between the top-level network controller and the per-layer engines.

---
 rtl/fire_sched_pkg.sv | 31 +++
 rtl/fire_sched_wdog.sv | 40 ++++
 rtl/fire_layer_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fire_sched_pkg.sv
// Shared types and width helpers for the fire-layer scheduler.
// The HALT state is only present when FIRE_SCHED_WATCHDOG_EN is defined.
package fire_sched_pkg;

`ifdef FIRE_SCHED_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_ACK  = 3'd2,
        S_DONE = 3'd3,
        S_HALT = 3'd4
    } fire_sched_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_ACK  = 3'd2,
        S_DONE = 3'd3
    } fire_sched_state_t;
`endif

    // Layer index is at least one bit wide so a single-layer chain still has a port.
    function automatic int layer_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fire_sched_wdog.sv
// Inactivity counter for the fire-layer scheduler; pulses expire_o for one
// cycle once run_i has been held for CYCLES cycles without a clear.
module fire_sched_wdog
    import fire_sched_pkg::*;
#(
    parameter int  CYCLES = 4096,
    localparam int W      = cnt_w(CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] r_cnt;
    logic         r_expire;

    // Count idle cycles while running; the count restarts after each expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else if (clr_i || !run_i) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt    <= '0;
            r_expire <= 1'b1;
        end else begin
            r_cnt    <= r_cnt + W'(1);
            r_expire <= 1'b0;
        end
    end

    assign expire_o = r_expire;

endmodule

// File: rtl/fire_layer_scheduler.sv
// Runs a chain of fire-layer engines one at a time over a shared feature-map RAM.
// Define FIRE_SCHED_WATCHDOG_EN to add the inactivity watchdog and HALT state.
module fire_layer_scheduler
    import fire_sched_pkg::*;
#(
    parameter int  NUM_LAYERS        = 4,
    parameter int  SAMPLES_PER_LAYER = 256,
    parameter int  WDOG_CYCLES       = 4096,
    localparam int LW                = layer_idx_w(NUM_LAYERS),
    localparam int CW                = cnt_w(SAMPLES_PER_LAYER)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic [NUM_LAYERS-1:0] layer_en_o,
    input  logic [NUM_LAYERS-1:0] layer_sample_i,
    input  logic [NUM_LAYERS-1:0] layer_finish_i,
    output logic [NUM_LAYERS-1:0] ram_feedback_o,
    output logic [LW-1:0]         cur_layer_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [CW-1:0]         CNT_FULL = CW'(SAMPLES_PER_LAYER);
    localparam logic [LW-1:0]         K_LAST   = LW'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] ONE      = NUM_LAYERS'(1);

    fire_sched_state_t     r_state;
    logic [LW-1:0]         r_k;
    logic [CW-1:0]         r_cnt;
    logic [NUM_LAYERS-1:0] r_en;
    logic [NUM_LAYERS-1:0] r_fb;
    logic [LW-1:0]         r_cur;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [NUM_LAYERS-1:0] w_onehot;
    logic                  w_sample;
    logic                  w_finish;

    // Only the active layer's strobes and finish are ever seen by the FSM.
    assign w_onehot = ONE << r_k;
    assign w_sample = |(layer_sample_i & w_onehot);
    assign w_finish = |(layer_finish_i & w_onehot);

`ifdef FIRE_SCHED_WATCHDOG_EN
    logic w_wdog_run;
    logic w_wdog_clr;
    logic w_expire;

    assign w_wdog_run = (r_state == S_RUN);
    assign w_wdog_clr = (r_state != S_RUN) | w_sample;

    fire_sched_wdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_wdog_clr),
        .run_i    (w_wdog_run),
        .expire_o (w_expire)
    );
`endif

    // Chain sequencer; outputs are a registered decode of the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_en    <= '0;
            r_fb    <= '0;
            r_cur   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_en   <= (r_state == S_RUN) ? w_onehot : '0;
            r_fb   <= (r_state == S_ACK) ? w_onehot : '0;
            r_cur  <= r_k;
            r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
            r_done <= (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_k     <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A sample coinciding with finish is counted before the ACK check.
                    if (w_sample && (r_cnt != CNT_FULL)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_finish) begin
                        r_state <= S_ACK;
`ifdef FIRE_SCHED_WATCHDOG_EN
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
`endif
                    end
                end
                S_ACK: begin
                    if (r_cnt != CNT_FULL) begin
                        r_err <= 1'b1;
                    end
                    r_cnt <= '0;
                    if (r_k == K_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k + LW'(1);
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
`ifdef FIRE_SCHED_WATCHDOG_EN
                S_HALT: begin
                    if (start_i) begin
                        r_k     <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign layer_en_o     = r_en;
    assign ram_feedback_o = r_fb;
    assign cur_layer_o    = r_cur;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign err_o          = r_err;

endmodule
